// File: rtl/reg_dump_ctrl_if.sv
// Output beat stream of the register dump controller: valid/ready handshake carrying
// one register word, its address and an end-of-dump marker.
interface reg_dump_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] idx;
  logic              last;

  modport master (output valid, data, idx, last, input ready);
  modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/reg_dump_ctrl.sv
// Debug dump master: halts the CPU, reads registers 0..NUM_REGS-1 through bank port A
// and streams each word out, then releases the CPU.
module reg_dump_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                halt_req,
  input  logic                halt_ack,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic                rf_rd,
  input  logic [DATA_W-1:0]   rf_data,
  reg_dump_ctrl_if.master     dump,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StHalt, StRead, StCapt, StSend, StRel} state_e;

  state_e            state;
  logic [ADDR_W-1:0] idx;
  logic              abort_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      idx        <= '0;
      abort_pend <= 1'b0;
      halt_req   <= 1'b0;
      rf_addr    <= '0;
      rf_rd      <= 1'b0;
      dump.valid <= 1'b0;
      dump.data  <= '0;
      dump.idx   <= '0;
      dump.last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != StIdle) abort_pend <= 1'b1;
      case (state)
        StIdle: begin
          // start wins over a same-cycle abort: abort_pend is cleared here
          if (start) begin
            state      <= StHalt;
            idx        <= '0;
            abort_pend <= 1'b0;
            halt_req   <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StHalt: begin
          if (abort || abort_pend) begin
            state    <= StRel;
            halt_req <= 1'b0;
          end else if (halt_ack) begin
            state   <= StRead;
            rf_addr <= idx;
            rf_rd   <= 1'b1;
          end
        end
        StRead: begin
          // a read only issues while the CPU is still parked; otherwise stall here
          if (rf_rd) begin
            rf_rd <= 1'b0;
            state <= StCapt;
          end else begin
            rf_rd <= halt_ack;
          end
        end
        StCapt: begin
          dump.data  <= rf_data;
          dump.idx   <= idx;
          dump.valid <= 1'b1;
          dump.last  <= (idx == LastIdx) || abort_pend || abort;
          state      <= StSend;
        end
        StSend: begin
          if (dump.ready) begin
            dump.valid <= 1'b0;
            dump.last  <= 1'b0;
            if (dump.last || abort_pend || abort) begin
              state    <= StRel;
              halt_req <= 1'b0;
            end else begin
              idx     <= idx + 1'b1;
              rf_addr <= idx + 1'b1;
              rf_rd   <= halt_ack;
              state   <= StRead;
            end
          end else if (abort) begin
            dump.last <= 1'b1;
          end
        end
        StRel: begin
          if (!halt_ack) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: table of dump scenarios against a register-bank model, plus
// directed reset and NUM_REGS=4 sequences.
module tb_reg_dump_ctrl;
  localparam int unsigned N   = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned N4  = 4;
  localparam int unsigned AW4 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start = 1'b0, abort = 1'b0, halt_ack = 1'b0;
  logic          halt_req, rf_rd, busy, done;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  reg_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

  reg_dump_ctrl #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .halt_req(halt_req),
    .halt_ack(halt_ack), .rf_addr(rf_addr), .rf_rd(rf_rd), .rf_data(rf_data),
    .dump(dif.master), .busy(busy), .done(done)
  );

  logic           start4 = 1'b0, halt_ack4 = 1'b0;
  logic           halt_req4, rf_rd4, busy4, done4;
  logic [AW4-1:0] rf_addr4;
  logic [DW-1:0]  rf_data4;
  reg_dump_ctrl_if #(.ADDR_W(AW4), .DATA_W(DW)) dif4 ();
  assign dif4.ready = 1'b1;

  reg_dump_ctrl #(.NUM_REGS(N4), .ADDR_W(AW4), .DATA_W(DW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(1'b0), .halt_req(halt_req4),
    .halt_ack(halt_ack4), .rf_addr(rf_addr4), .rf_rd(rf_rd4), .rf_data(rf_data4),
    .dump(dif4.master), .busy(busy4), .done(done4)
  );

  // Register bank model: port A samples on negedge when read strobe is high
  logic [DW-1:0] bank [N];
  always @(negedge clk) if (rf_rd) rf_data <= bank[rf_addr];
  always @(negedge clk) if (rf_rd4) rf_data4 <= bank[rf_addr4];

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scenario knobs read by the driver process
  int ack_delay = 0, ready_pct = 100, stall_beat = -1, stall_len = 5, abort_beat = -1;
  int ack_cnt = 0, stall_left = 0;
  bit abort_fired = 1'b0;

  always @(posedge clk) begin
    #1;
    if (halt_req !== halt_ack) begin
      if (ack_cnt >= ack_delay) begin
        halt_ack = halt_req;
        ack_cnt  = 0;
      end else ack_cnt++;
    end else ack_cnt = 0;
    if (!busy) begin
      stall_left  = stall_len;
      abort_fired = 1'b0;
    end
    if (stall_beat >= 0 && dif.valid && int'(dif.idx) == stall_beat && stall_left > 0) begin
      dif.ready = 1'b0;
      stall_left--;
    end else dif.ready = ($urandom_range(99) < ready_pct);
    if (!abort_fired && ((abort_beat >= 0 && rf_rd && int'(rf_addr) == abort_beat) ||
                         (abort_beat == -2 && busy && !halt_ack))) begin
      abort       = 1'b1;
      abort_fired = 1'b1;
    end else abort = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    halt_ack4 = halt_req4;
  end

  typedef struct {int idx; logic [DW-1:0] data; bit last;} beat_t;
  beat_t beats[$];
  beat_t beats4[$];
  int cyc = 0, rd_cnt = 0, viol = 0, done_cnt = 0, t_ack = 0, t_last = 0;
  int rd4_cnt = 0, done4_cnt = 0;
  bit pv = 1'b0, pr = 1'b0, pa = 1'b0;
  logic [DW-1:0] pd;
  logic [AW-1:0] pi;

  // Observe away from the posedge: handshakes, read strobes and stream stability
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) pv = 1'b0;
    else begin
      if (dif.valid && dif.ready) begin
        beats.push_back('{idx: int'(dif.idx), data: dif.data, last: dif.last});
        if (dif.last) t_last = cyc;
      end
      if (halt_ack && !pa) t_ack = cyc;
      if (rf_rd) begin
        rd_cnt++;
        if (!halt_ack || dif.valid) viol++;
      end
      if (done) done_cnt++;
      if (pv && !pr && (!dif.valid || dif.data !== pd || dif.idx !== pi)) viol++;
      pv = dif.valid;
      pr = dif.ready;
      pd = dif.data;
      pi = dif.idx;
      if (dif4.valid) beats4.push_back('{idx: int'(dif4.idx), data: dif4.data, last: dif4.last});
      if (rf_rd4) rd4_cnt++;
      if (done4) done4_cnt++;
    end
    pa = halt_ack;
  end

  typedef struct {
    int ack_delay; int ready_pct; int stall_beat; int abort_beat;
    int repulse;   int ramp;      int exp_beats;
  } vec_t;
  vec_t vecs[8];

  task automatic check_zero(input string tag);
    check({tag, " halt_req"}, halt_req, 0);
    check({tag, " rf_rd"}, rf_rd, 0);
    check({tag, " out_valid"}, dif.valid, 0);
    check({tag, " out_last"}, dif.last, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " rf_addr"}, rf_addr, 0);
    check({tag, " out_idx"}, dif.idx, 0);
    check({tag, " out_data"}, dif.data, 0);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   b0, r0, v0, d0, nb;
    v = vecs[k];
    ack_delay  = v.ack_delay;
    ready_pct  = v.ready_pct;
    stall_beat = v.stall_beat;
    abort_beat = v.abort_beat;
    stall_len  = 5;
    for (int i = 0; i < N; i++)
      bank[i] = (v.ramp != 0) ? ((i == 14) ? 32'h0040_0000 : 32'(i)) : $urandom();
    b0 = beats.size(); r0 = rd_cnt; v0 = viol; d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (v.repulse != 0) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int c = 0; c < 4000 && done_cnt == d0; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    check($sformatf("v%0d done pulses", k), done_cnt - d0, 1);
    check($sformatf("v%0d busy after", k), busy, 0);
    check($sformatf("v%0d halt_req after", k), halt_req, 0);
    nb = beats.size() - b0;
    check($sformatf("v%0d beat count", k), nb, v.exp_beats);
    check($sformatf("v%0d rf_rd count", k), rd_cnt - r0, v.exp_beats);
    check($sformatf("v%0d protocol violations", k), viol - v0, 0);
    for (int i = 0; i < nb && i < v.exp_beats; i++) begin
      check($sformatf("v%0d beat%0d idx", k, i), beats[b0+i].idx, i);
      check($sformatf("v%0d beat%0d data", k, i), beats[b0+i].data, bank[i]);
      check($sformatf("v%0d beat%0d last", k, i), beats[b0+i].last, (i == v.exp_beats - 1));
    end
    if (v.ready_pct == 100 && v.stall_beat < 0 && v.abort_beat == -1)
      check($sformatf("v%0d cycles ack->last", k), t_last - t_ack, 3 * v.exp_beats);
  endtask

  initial begin
    bit ok;
    // ack_delay, ready%, stall_beat, abort_beat(-2: in HALT), repulse, ramp, beats
    vecs[0] = '{0, 100, -1, -1, 0, 1, 32};
    vecs[1] = '{1, 100,  3, -1, 0, 0, 32};
    vecs[2] = '{0, 100, -1,  7, 0, 0,  8};
    vecs[3] = '{10, 100, -1, -1, 1, 0, 32};
    vecs[4] = '{2,  50, -1, -1, 0, 0, 32};
    vecs[5] = '{3,  30, -1, 20, 0, 0, 21};
    vecs[6] = '{10, 100, -1, -2, 0, 0, 0};
    vecs[7] = '{0,  70, -1,  0, 0, 0,  1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(k);

    // Asynchronous reset while a beat is parked in SEND
    ack_delay = 0; ready_pct = 100; stall_beat = 2; stall_len = 1000; abort_beat = -1;
    bank[2] = 32'hDEAD_BEEF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      ok = dif.valid && dif.idx == 2;
    end
    check("reach SEND before reset", ok, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid-dump reset");
    stall_beat = -1; stall_len = 5;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post-reset busy", busy, 0);
    check("post-reset halt_req", halt_req, 0);
    run_vec(4);

    // Minimum-size build: four registers, 2-bit addresses
    begin
      int b4, d4, r4;
      b4 = beats4.size(); d4 = done4_cnt; r4 = rd4_cnt;
      @(posedge clk); #1 start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
      for (int c = 0; c < 500 && done4_cnt == d4; c++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("n4 done pulses", done4_cnt - d4, 1);
      check("n4 beat count", beats4.size() - b4, N4);
      check("n4 rf_rd count", rd4_cnt - r4, N4);
      check("n4 busy after", busy4, 0);
      for (int i = 0; i < N4 && b4 + i < beats4.size(); i++) begin
        check($sformatf("n4 beat%0d idx", i), beats4[b4+i].idx, i);
        check($sformatf("n4 beat%0d data", i), beats4[b4+i].data, bank[i]);
        check($sformatf("n4 beat%0d last", i), beats4[b4+i].last, (i == N4 - 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
